// File: rtl/demux_1x32_deser.sv
// Receive-side 1:WIDTH serial-to-parallel demultiplexer with a valid/ready word output.
// Bits arrive LSB first; din_sof realigns the slot counter.
module demux_1x32_deser #(
   parameter int WIDTH = 32,
   parameter int SEL_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             din_valid,
   input  logic             din_sof,
   output logic             din_ready,
   output logic [SEL_W-1:0] sel,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             sync_err
);

   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(WIDTH - 1);

   logic [SEL_W-1:0] sel_r;
   logic [SEL_W-1:0] sel_nxt_s;
   logic [WIDTH-1:0] asm_r;
   logic [WIDTH-1:0] asm_nxt_s;
   logic [WIDTH-1:0] dout_r;
   logic [WIDTH-1:0] dout_nxt_s;
   logic             dout_valid_r;
   logic             dout_valid_nxt_s;
   logic             sync_err_r;
   logic             sync_err_nxt_s;
   logic             last_s;
   logic             ready_s;
   logic             acc_s;
   logic             complete_s;
   logic             take_s;

   // Handshake qualifiers; only the final slot can stall, and only behind an untaken word.
   always_comb begin
      last_s     = (sel_r == SEL_LAST);
      ready_s    = !(last_s && dout_valid_r && !dout_ready);
      acc_s      = din_valid && ready_s;
      complete_s = acc_s && !din_sof && last_s;
      take_s     = dout_valid_r && dout_ready;
   end

   // Demux the accepted bit into its slot and advance the select counter.
   always_comb begin
      asm_nxt_s = asm_r;
      sel_nxt_s = sel_r;
      if (acc_s) begin
         if (din_sof) begin
            asm_nxt_s    = {WIDTH{1'b0}};
            asm_nxt_s[0] = din;
            sel_nxt_s    = SEL_W'(1);
         end else begin
            asm_nxt_s[sel_r] = din;
            sel_nxt_s        = sel_r + SEL_W'(1);
         end
      end else begin
         asm_nxt_s = asm_r;
         sel_nxt_s = sel_r;
      end
   end

   // Output holding register: a completion reloads it even while the old word is being taken.
   always_comb begin
      dout_nxt_s       = dout_r;
      dout_valid_nxt_s = dout_valid_r;
      if (complete_s) begin
         dout_nxt_s       = asm_nxt_s;
         dout_valid_nxt_s = 1'b1;
      end else if (take_s) begin
         dout_nxt_s       = dout_r;
         dout_valid_nxt_s = 1'b0;
      end else begin
         dout_nxt_s       = dout_r;
         dout_valid_nxt_s = dout_valid_r;
      end
      sync_err_nxt_s = acc_s && din_sof && (sel_r != SEL_W'(0));
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sel_r        <= {SEL_W{1'b0}};
         asm_r        <= {WIDTH{1'b0}};
         dout_r       <= {WIDTH{1'b0}};
         dout_valid_r <= 1'b0;
         sync_err_r   <= 1'b0;
      end else begin
         sel_r        <= sel_nxt_s;
         asm_r        <= asm_nxt_s;
         dout_r       <= dout_nxt_s;
         dout_valid_r <= dout_valid_nxt_s;
         sync_err_r   <= sync_err_nxt_s;
      end
   end

   assign sel        = sel_r;
   assign dout       = dout_r;
   assign dout_valid = dout_valid_r;
   assign sync_err   = sync_err_r;
   assign din_ready  = ready_s;

endmodule

// File: tb/tb_demux_1x32_deser.sv
// Directed bench for demux_1x32_deser: reset, single word, backpressure,
// resync, gapped input and mid-word reset.
module tb_demux_1x32_deser;

   logic        clk = 1'b0;
   logic        rst;
   logic        din;
   logic        din_valid;
   logic        din_sof;
   logic        din_ready;
   logic [4:0]  sel;
   logic [31:0] dout;
   logic        dout_valid;
   logic        dout_ready;
   logic        sync_err;

   int checks = 0;
   int errors = 0;
   logic        t5_on = 1'b0;
   logic [31:0] got_q[$];
   logic [31:0] words[8] = '{32'h0000_0001, 32'h8000_0000, 32'hDEAD_BEEF, 32'h0123_4567,
                             32'hFFFF_FFFF, 32'h5555_AAAA, 32'h0000_0000, 32'hC001_D00D};

   demux_1x32_deser dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_sof(din_sof),
      .din_ready(din_ready), .sel(sel), .dout(dout), .dout_valid(dout_valid),
      .dout_ready(dout_ready), .sync_err(sync_err)
   );

   always #5 clk = ~clk;

   // Collect words delivered during the gapped-input test.
   always @(negedge clk) begin
      if (t5_on && !rst && dout_valid && dout_ready) got_q.push_back(dout);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input logic s);
      din = b; din_valid = 1'b1; din_sof = s;
      tick();
      din = 1'b0; din_valid = 1'b0; din_sof = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 32; i++) send_bit(w[i], (i == 0));
   endtask

   initial begin
      logic [31:0] w;
      rst = 1'b1; din = 1'b0; din_valid = 1'b0; din_sof = 1'b0; dout_ready = 1'b0;

      // T1 reset / idle
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("t1_sel", {27'd0, sel}, 32'd0);
      chk("t1_dout", dout, 32'h0);
      chk("t1_dout_valid", {31'd0, dout_valid}, 32'd0);
      chk("t1_din_ready", {31'd0, din_ready}, 32'd1);
      chk("t1_sync_err", {31'd0, sync_err}, 32'd0);

      // T2 single word
      dout_ready = 1'b1;
      w = 32'hA5C3_0F1E;
      for (int i = 0; i < 31; i++) send_bit(w[i], (i == 0));
      chk("t2_valid_before_last", {31'd0, dout_valid}, 32'd0);
      chk("t2_sel_before_last", {27'd0, sel}, 32'd31);
      send_bit(w[31], 1'b0);
      chk("t2_dout", dout, 32'hA5C3_0F1E);
      chk("t2_dout_valid", {31'd0, dout_valid}, 32'd1);
      chk("t2_sel_wrap", {27'd0, sel}, 32'd0);
      tick();
      chk("t2_valid_drop", {31'd0, dout_valid}, 32'd0);
      chk("t2_dout_hold", dout, 32'hA5C3_0F1E);

      // T3 backpressure
      dout_ready = 1'b0;
      send_word(32'h1234_5678);
      chk("t3_w1_dout", dout, 32'h1234_5678);
      chk("t3_w1_valid", {31'd0, dout_valid}, 32'd1);
      w = 32'hFFFF_0000;
      for (int i = 0; i < 31; i++) send_bit(w[i], (i == 0));
      chk("t3_sel31", {27'd0, sel}, 32'd31);
      din = w[31]; din_valid = 1'b1;
      #1;
      chk("t3_stall_ready", {31'd0, din_ready}, 32'd0);
      tick();
      chk("t3_stall_sel", {27'd0, sel}, 32'd31);
      chk("t3_stall_dout", dout, 32'h1234_5678);
      dout_ready = 1'b1;
      #1;
      chk("t3_ready_comb", {31'd0, din_ready}, 32'd1);
      tick();
      din_valid = 1'b0; din = 1'b0;
      chk("t3_w2_dout", dout, 32'hFFFF_0000);
      chk("t3_w2_valid", {31'd0, dout_valid}, 32'd1);
      chk("t3_sel_wrap", {27'd0, sel}, 32'd0);
      tick();
      chk("t3_valid_drop", {31'd0, dout_valid}, 32'd0);

      // T4 resync
      for (int i = 0; i < 10; i++) send_bit(1'b1, (i == 0));
      chk("t4_sel10", {27'd0, sel}, 32'd10);
      chk("t4_no_err_yet", {31'd0, sync_err}, 32'd0);
      send_bit(1'b1, 1'b1);
      chk("t4_sync_err", {31'd0, sync_err}, 32'd1);
      chk("t4_sel1", {27'd0, sel}, 32'd1);
      send_bit(1'b0, 1'b0);
      chk("t4_sync_err_pulse", {31'd0, sync_err}, 32'd0);
      for (int i = 0; i < 30; i++) send_bit(1'b0, 1'b0);
      chk("t4_dout", dout, 32'h0000_0001);
      chk("t4_valid", {31'd0, dout_valid}, 32'd1);
      tick();

      // T5 gapped input, ~40% duty
      t5_on = 1'b1;
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < 32; i++) begin
            while ($urandom_range(0, 9) >= 4) tick();
            send_bit(words[k][i], (i == 0));
         end
      end
      tick(); tick();
      t5_on = 1'b0;
      chk("t5_count", got_q.size(), 32'd8);
      for (int k = 0; k < 8; k++) begin
         if (k < got_q.size()) chk($sformatf("t5_word%0d", k), got_q[k], words[k]);
      end

      // T6 mid-word reset
      for (int i = 0; i < 17; i++) send_bit(1'b1, (i == 0));
      chk("t6_sel17", {27'd0, sel}, 32'd17);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("t6_sel", {27'd0, sel}, 32'd0);
      chk("t6_dout", dout, 32'h0);
      chk("t6_valid", {31'd0, dout_valid}, 32'd0);
      chk("t6_sync_err", {31'd0, sync_err}, 32'd0);
      chk("t6_din_ready", {31'd0, din_ready}, 32'd1);
      w = 32'h8000_0000;
      for (int i = 0; i < 32; i++) send_bit(w[i], 1'b0);
      chk("t6_word", dout, 32'h8000_0000);
      chk("t6_word_valid", {31'd0, dout_valid}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
